// File: rtl/accel_pkg.sv
// Definitions shared by the tile loader and the store engine.
package accel_pkg;

    localparam int unsigned ADDR_WIDTH = 24;
    localparam int unsigned LEN_WIDTH  = 20;

    typedef enum logic [1:0] {
        StIdle,
        StWaitTile,
        StWrite,
        StDone
    } xfer_state_e;

endpackage

// File: rtl/tile_serializer.sv
// TILE_WIDTH-to-8 MSB-first serializer. Byte 0 is taken straight from tile_in on load,
// so it can be written in the same cycle the tile is accepted.
module tile_serializer #(
    parameter int unsigned TILE_WIDTH = 256,
    localparam int unsigned NUM_BYTES = TILE_WIDTH / 8,
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [TILE_WIDTH-1:0] tile_in,
    output logic [7:0]            byte_out,
    output logic [IDX_W-1:0]      byte_idx
);

    logic [TILE_WIDTH-1:0] tile_q;
    logic [IDX_W-1:0]      idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            tile_q <= tile_in << 8;
            idx_q  <= IDX_W'(1);
        end else if (shift) begin
            tile_q <= tile_q << 8;
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    assign byte_out = load ? tile_in[TILE_WIDTH-1 -: 8] : tile_q[TILE_WIDTH-1 -: 8];
    assign byte_idx = load ? '0 : idx_q;

endmodule

// File: rtl/store_m.sv
// Tile write-back engine: accepts tiles and writes them byte by byte to DRAM.
// Define STORE_M_PAD_EN to always write the final tile in full.
module store_m
    import accel_pkg::*;
#(
    parameter int unsigned TILE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [TILE_WIDTH-1:0] tile_in,
    input  logic                  tile_valid,
    output logic                  tile_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_din,
    output logic                  busy,
    output logic                  valid_out
);

    localparam int unsigned NUM_BYTES = TILE_WIDTH / 8;
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    // One bit wider than 17 so that lengths near 2^20 bits do not wrap to zero bytes.
    localparam int unsigned CNT_W     = LEN_WIDTH - 2;

    xfer_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      left_q, left_d;
    logic                  last_q, last_d;
    logic                  tile_ready_q, tile_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_din_q, mem_din_d;
    logic                  busy_q, busy_d;
    logic                  valid_out_q, valid_out_d;

    logic                  ser_load, ser_shift, emit;
    logic [7:0]            ser_byte;
    logic [IDX_W-1:0]      ser_idx;
    logic [LEN_WIDTH:0]    len_sum;
    logic [CNT_W-1:0]      len_bytes;

    assign len_sum   = {1'b0, length} + (LEN_WIDTH + 1)'(7);
    assign len_bytes = len_sum[LEN_WIDTH:3];

    tile_serializer #(
        .TILE_WIDTH(TILE_WIDTH)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .shift    (ser_shift),
        .tile_in  (tile_in),
        .byte_out (ser_byte),
        .byte_idx (ser_idx)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        left_d     = left_q;
        last_d     = last_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;
        emit       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    addr_d  = dram_addr;
                    left_d  = len_bytes;
                    state_d = (len_bytes == '0) ? StDone : StWaitTile;
                end
            end
            StWaitTile: begin
                if (tile_valid && tile_ready_q) begin
                    ser_load = 1'b1;
                    emit     = 1'b1;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                // last_q marks that the byte on the bus now is the tile's final one.
                if (last_q) begin
                    state_d = (left_q == '0) ? StDone : StWaitTile;
                end else begin
                    ser_shift = 1'b1;
                    emit      = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (emit) begin
            mem_addr_d = addr_q;
            mem_din_d  = ser_byte;
            addr_d     = addr_q + ADDR_WIDTH'(1);
            left_d     = (left_q == '0) ? '0 : left_q - CNT_W'(1);
`ifdef STORE_M_PAD_EN
            last_d     = (ser_idx == IDX_W'(NUM_BYTES - 1));
`else
            last_d     = (ser_idx == IDX_W'(NUM_BYTES - 1)) || (left_q == CNT_W'(1));
`endif
        end

        mem_we_d     = emit;
        tile_ready_d = (state_d == StWaitTile);
        busy_d       = (state_d != StIdle);
        valid_out_d  = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            left_q       <= '0;
            last_q       <= 1'b0;
            tile_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            busy_q       <= 1'b0;
            valid_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            left_q       <= left_d;
            last_q       <= last_d;
            tile_ready_q <= tile_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            busy_q       <= busy_d;
            valid_out_q  <= valid_out_d;
        end
    end

    assign tile_ready = tile_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign busy       = busy_q;
    assign valid_out  = valid_out_q;

endmodule

// File: tb/tb_store_m.sv
// Directed self-checking bench for store_m with 32-bit tiles.
module tb_store_m;

    localparam int unsigned TW = 32;
`ifdef STORE_M_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic [23:0]   dram_addr = '0;
    logic [19:0]   length = '0;
    logic [TW-1:0] tile_in = '0;
    logic          tile_valid = 1'b0;
    logic          tile_ready, mem_we, busy, valid_out;
    logic [23:0]   mem_addr;
    logic [7:0]    mem_din;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vo_cnt = 0;
    int vo_cyc = 0;
    int tr_cnt = 0;
    int start_cyc = 0;
    int hs_cyc = 0;
    logic [23:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int          wr_cyc[$];

    store_m #(
        .TILE_WIDTH(TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .dram_addr  (dram_addr),
        .length     (length),
        .tile_in    (tile_in),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .busy       (busy),
        .valid_out  (valid_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_din);
            wr_cyc.push_back(cyc);
        end
        if (valid_out === 1'b1) begin
            vo_cnt <= vo_cnt + 1;
            vo_cyc <= cyc;
        end
        if (tile_ready === 1'b1) tr_cnt <= tr_cnt + 1;
    end

    task automatic start_xfer(input logic [23:0] a, input logic [19:0] l);
        valid_in  = 1'b1;
        dram_addr = a;
        length    = l;
        @(posedge clk); #1;
        start_cyc = cyc;
        valid_in  = 1'b0;
    endtask

    task automatic send_tile(input logic [TW-1:0] t);
        bit done = 1'b0;
        tile_in    = t;
        tile_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (tile_ready === 1'b1) done = 1'b1;
            @(posedge clk); #1;
        end
        hs_cyc     = cyc;
        tile_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL tile_handshake: tile_ready stayed %b for 50 cycles, required 1", tile_ready);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b after 300 cycles, required 0", busy);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({tile_ready, mem_we, busy, valid_out} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready/we/busy/vo=%b, required 0000",
                     {tile_ready, mem_we, busy, valid_out});
        end
        checks++;
        if ({mem_addr, mem_din} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h din=%h, required 000000 00", mem_addr, mem_din);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({tile_ready, busy} !== 2'b0) begin
            errors++;
            $display("FAIL reset_idle: ready/busy=%b, required 00", {tile_ready, busy});
        end
    endtask

    task automatic test_full_tiles();
        int base = wr_addr.size();
        int vb = vo_cnt;
        int h1;
        int n;
        logic [63:0] exp = 64'h1122334455667788;
        start_xfer(24'h000100, 20'd64);
        checks++;
        if (tile_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_after_start: tile_ready=%b, required 1", tile_ready);
        end
        send_tile(32'h11223344);
        h1 = hs_cyc;
        send_tile(32'h55667788);
        wait_idle();
        n = wr_addr.size() - base;
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL full_count: %0d writes, required 8", n);
        end
        for (int i = 0; i < 8 && i < n; i++) begin
            checks++;
            if (wr_addr[base+i] !== 24'h000100 + 24'(i) || wr_data[base+i] !== exp[63-8*i -: 8]) begin
                errors++;
                $display("FAIL full_byte%0d: %h@%h, required %h@%h", i, wr_data[base+i],
                         wr_addr[base+i], exp[63-8*i -: 8], 24'h000100 + 24'(i));
            end
        end
        checks++;
        if (n > 0 && wr_cyc[base] != h1) begin
            errors++;
            $display("FAIL full_latency: first write cycle %0d, required %0d", wr_cyc[base], h1);
        end
        checks++;
        if (vo_cnt - vb != 1 || vo_cyc != wr_cyc[wr_cyc.size()-1] + 1) begin
            errors++;
            $display("FAIL full_valid_out: %0d pulses at cycle %0d, required 1 at %0d",
                     vo_cnt - vb, vo_cyc, wr_cyc[wr_cyc.size()-1] + 1);
        end
    endtask

    task automatic test_partial();
        int base = wr_addr.size();
        int n;
        int n_exp = PAD ? 8 : 5;
        logic [63:0] exp = 64'hAABBCCDDEEFF0011;
        start_xfer(24'h000200, 20'd40);
        send_tile(32'hAABBCCDD);
        send_tile(32'hEEFF0011);
        wait_idle();
        n = wr_addr.size() - base;
        checks++;
        if (n != n_exp) begin
            errors++;
            $display("FAIL partial_count: %0d writes, required %0d", n, n_exp);
        end
        for (int i = 0; i < n_exp && i < n; i++) begin
            checks++;
            if (wr_addr[base+i] !== 24'h000200 + 24'(i) || wr_data[base+i] !== exp[63-8*i -: 8]) begin
                errors++;
                $display("FAIL partial_byte%0d: %h@%h, required %h@%h", i, wr_data[base+i],
                         wr_addr[base+i], exp[63-8*i -: 8], 24'h000200 + 24'(i));
            end
        end
    endtask

    task automatic test_zero_len();
        int base = wr_addr.size();
        int vb = vo_cnt;
        int tb0 = tr_cnt;
        int n;
        int n_exp = PAD ? 4 : 2;
        logic [31:0] exp = 32'hCAFEBABE;
        tile_in    = 32'h99999999;
        tile_valid = 1'b1;
        start_xfer(24'h000000, 20'd0);
        checks++;
        if ({valid_out, tile_ready, busy} !== 3'b101) begin
            errors++;
            $display("FAIL zero_done: vo/ready/busy=%b, required 101", {valid_out, tile_ready, busy});
        end
        repeat (3) begin @(posedge clk); #1; end
        tile_valid = 1'b0;
        checks++;
        if (wr_addr.size() != base || tr_cnt != tb0 || vo_cnt - vb != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_quiet: writes=%0d ready_cycles=%0d pulses=%0d busy=%b, required 0 0 1 0",
                     wr_addr.size() - base, tr_cnt - tb0, vo_cnt - vb, busy);
        end
        base = wr_addr.size();
        start_xfer(24'h000300, 20'd12);
        send_tile(32'hCAFEBABE);
        wait_idle();
        n = wr_addr.size() - base;
        checks++;
        if (n != n_exp) begin
            errors++;
            $display("FAIL sub_byte_count: %0d writes, required %0d", n, n_exp);
        end
        for (int i = 0; i < n_exp && i < n; i++) begin
            checks++;
            if (wr_addr[base+i] !== 24'h000300 + 24'(i) || wr_data[base+i] !== exp[31-8*i -: 8]) begin
                errors++;
                $display("FAIL sub_byte_byte%0d: %h@%h, required %h@%h", i, wr_data[base+i],
                         wr_addr[base+i], exp[31-8*i -: 8], 24'h000300 + 24'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int base = wr_addr.size();
        int vb = vo_cnt;
        int n;
        logic [31:0] exp = 32'h0A0B0C0D;
        start_xfer(24'h000400, 20'd32);
        for (int i = 0; i < 5; i++) begin
            valid_in  = (i == 2);
            dram_addr = 24'h000999;
            length    = 20'd8;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        checks++;
        if (tile_ready !== 1'b1 || wr_addr.size() != base) begin
            errors++;
            $display("FAIL bp_wait: ready=%b writes=%0d, required 1 0", tile_ready, wr_addr.size() - base);
        end
        send_tile(32'h0A0B0C0D);
        wait_idle();
        repeat (5) begin @(posedge clk); #1; end
        n = wr_addr.size() - base;
        checks++;
        if (n != 4 || busy !== 1'b0 || vo_cnt - vb != 1) begin
            errors++;
            $display("FAIL bp_count: writes=%0d busy=%b pulses=%0d, required 4 0 1", n, busy, vo_cnt - vb);
        end
        checks++;
        if (n > 0 && wr_cyc[base] != hs_cyc) begin
            errors++;
            $display("FAIL bp_latency: first write cycle %0d, required %0d", wr_cyc[base], hs_cyc);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++;
            if (wr_addr[base+i] !== 24'h000400 + 24'(i) || wr_data[base+i] !== exp[31-8*i -: 8]) begin
                errors++;
                $display("FAIL bp_byte%0d: %h@%h, required %h@%h", i, wr_data[base+i],
                         wr_addr[base+i], exp[31-8*i -: 8], 24'h000400 + 24'(i));
            end
        end
    endtask

    task automatic test_wrap();
        int base = wr_addr.size();
        int n;
        logic [31:0] exp = 32'h01020304;
        logic [23:0] a;
        start_xfer(24'hFFFFFE, 20'd32);
        send_tile(32'h01020304);
        wait_idle();
        n = wr_addr.size() - base;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL wrap_count: %0d writes, required 4", n);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            a = 24'hFFFFFE + 24'(i);
            checks++;
            if (wr_addr[base+i] !== a || wr_data[base+i] !== exp[31-8*i -: 8]) begin
                errors++;
                $display("FAIL wrap_byte%0d: %h@%h, required %h@%h", i, wr_data[base+i],
                         wr_addr[base+i], exp[31-8*i -: 8], a);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base = wr_addr.size();
        int vb = vo_cnt;
        int n;
        logic [31:0] exp = 32'hDEADBEEF;
        start_xfer(24'h000500, 20'd64);
        send_tile(32'h12345678);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({tile_ready, mem_we, busy, valid_out, mem_addr, mem_din} !== 36'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ready/we/busy/vo=%b addr=%h din=%h, required all 0",
                     {tile_ready, mem_we, busy, valid_out}, mem_addr, mem_din);
        end
        checks++;
        if (wr_addr.size() - base != 2) begin
            errors++;
            $display("FAIL mid_reset_partial: %0d writes before reset, required 2", wr_addr.size() - base);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        base = wr_addr.size();
        start_xfer(24'h000010, 20'd32);
        send_tile(32'hDEADBEEF);
        wait_idle();
        n = wr_addr.size() - base;
        checks++;
        if (n != 4 || vo_cnt - vb != 1) begin
            errors++;
            $display("FAIL mid_reset_restart: writes=%0d pulses=%0d, required 4 1", n, vo_cnt - vb);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++;
            if (wr_addr[base+i] !== 24'h000010 + 24'(i) || wr_data[base+i] !== exp[31-8*i -: 8]) begin
                errors++;
                $display("FAIL mid_reset_byte%0d: %h@%h, required %h@%h", i, wr_data[base+i],
                         wr_addr[base+i], exp[31-8*i -: 8], 24'h000010 + 24'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_tiles();
        test_partial();
        test_zero_len();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
